// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage: operand-fetch stage with write-back forwarding, register-0 zeroing and a valid/ready output register
// Ports:
//   clock, ctrl_reset_n          clock and asynchronous active-low reset
//   in_valid/in_ready/in_rs1/2   decode-side handshake and source indices
//   ctrl_readRegA/B              register file read-port selects (combinational copy of in_rs1/2)
//   data_readRegA/B              register file read-port data (valid in the same cycle)
//   wb_en/wb_reg/wb_data         write landing in the register file at the next edge
//   flush                        discard held operands and any same-cycle capture
//   out_valid/out_ready/out_*    execute-side handshake, held indices and operands
//   bypass_cnt                   saturating count of forwarded operands
module regfile_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    output logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    output logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0] data_readRegA,
    input  logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_rs1,
    output logic [ADDR_WIDTH-1:0] out_rs2,
    output logic [DATA_WIDTH-1:0] out_opA,
    output logic [DATA_WIDTH-1:0] out_opB,
    output logic [15:0]           bypass_cnt
);
    logic                  capture;
    logic                  hold;
    logic                  wb_live;
    logic                  cap_fwd_a;
    logic                  cap_fwd_b;
    logic                  hold_fwd_a;
    logic                  hold_fwd_b;
    logic [1:0]            fwd_inc;
    logic [16:0]           cnt_sum;
    logic [DATA_WIDTH-1:0] op_a_next;
    logic [DATA_WIDTH-1:0] op_b_next;

    assign ctrl_readRegA = in_rs1;
    assign ctrl_readRegB = in_rs2;
    assign in_ready      = !out_valid || out_ready;
    assign capture       = in_valid && in_ready && !flush;
    assign hold          = out_valid && !out_ready && !flush;
    // a write to register 0 is discarded by the register file, so it never forwards
    assign wb_live       = wb_en && wb_reg != '0;
    assign cap_fwd_a     = wb_live && wb_reg == in_rs1;
    assign cap_fwd_b     = wb_live && wb_reg == in_rs2;
    assign hold_fwd_a    = wb_live && wb_reg == out_rs1;
    assign hold_fwd_b    = wb_live && wb_reg == out_rs2;

    // the read port still shows the pre-write value at the write edge, so a matching write wins
    always_comb begin
        op_a_next = in_rs1 == '0 ? '0 : cap_fwd_a ? wb_data : data_readRegA;
        op_b_next = in_rs2 == '0 ? '0 : cap_fwd_b ? wb_data : data_readRegB;
        fwd_inc   = capture ? {1'b0, cap_fwd_a} + {1'b0, cap_fwd_b}
                  : hold    ? {1'b0, hold_fwd_a} + {1'b0, hold_fwd_b}
                  : 2'd0;
        cnt_sum   = {1'b0, bypass_cnt} + {15'd0, fwd_inc};
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            out_valid  <= 1'b0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_opA    <= '0;
            out_opB    <= '0;
            bypass_cnt <= '0;
        end else begin
            out_valid  <= !flush && (capture || (out_valid && !out_ready));
            bypass_cnt <= cnt_sum[16] ? '1 : cnt_sum[15:0];
            if (capture) begin
                out_rs1 <= in_rs1;
                out_rs2 <= in_rs2;
                out_opA <= op_a_next;
                out_opB <= op_b_next;
            end else if (hold) begin
                // keep a stalled operand current with the register it names
                if (hold_fwd_a) out_opA <= wb_data;
                if (hold_fwd_b) out_opB <= wb_data;
            end
        end
    end
endmodule
